// File: rtl/mul_acc_ctrl_pkg.sv
// Shared definitions for the multiply-accumulate front-end.
// Holds the FSM state encoding, the multiplier operand/product widths
// and the default frame parameters used by mul_acc_ctrl.
package mul_acc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam int MUL_IN_W  = 16;
    localparam int MUL_OUT_W = 19;

    localparam int DEF_ACC_W = 24;
    localparam int DEF_COUNT = 8;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/mul_acc_ctrl_sat_add.sv
// Saturating adder: acc (ACC_W bits) + product (MUL_OUT_W bits, zero-extended).
// Latency: combinational. Backpressure: none (pure datapath).
// Ports: acc/addend in, sum out (clamped to all-ones), ovf high when clamped.
module mul_acc_ctrl_sat_add
    import mul_acc_ctrl_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic [MUL_OUT_W-1:0] addend,
    output logic [ACC_W-1:0]     sum,
    output logic                 ovf
);

    // One extra bit catches the carry out; ACC_W >= MUL_OUT_W keeps the
    // zero-extension width non-negative.
    logic [ACC_W:0] wide;

    assign wide = {1'b0, acc} + {{(ACC_W + 1 - MUL_OUT_W){1'b0}}, addend};
    assign ovf  = wide[ACC_W];
    assign sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/mul_acc_ctrl.sv
// Sequencer/accumulator in front of the external 16x16->19 multiplier; sums a frame of products.
// Latency: 2 cycles from accepting the closing pair to out_valid; one pair accepted every 2 cycles.
// Backpressure: in_ready only in S_IDLE; S_OUT holds out_* stable until out_ready; clr aborts anywhere.
// Ports: m_clock/p_reset (async, active-low), clr; in_* operand handshake; mul_* to multiplier;
//        out_* frame result handshake (sum, product count, saturation flag).
module mul_acc_ctrl
    import mul_acc_ctrl_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,  // >= MUL_OUT_W
    parameter int COUNT = DEF_COUNT,  // >= 1
    parameter int CNT_W = DEF_CNT_W   // 2**CNT_W > COUNT
) (
    input  logic                 m_clock,
    input  logic                 p_reset,
    input  logic                 clr,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MUL_IN_W-1:0]  in_a,
    input  logic [MUL_IN_W-1:0]  in_b,
    input  logic                 in_last,

    output logic [MUL_IN_W-1:0]  mul_a,
    output logic [MUL_IN_W-1:0]  mul_b,
    output logic                 mul_exe,
    input  logic [MUL_OUT_W-1:0] mul_result,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    state_t           state;
    logic             last_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] acc_next;
    logic             add_ovf;

    mul_acc_ctrl_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc    (acc),
        .addend (mul_result),
        .sum    (acc_next),
        .ovf    (add_ovf)
    );

    // The frame registers only change in S_MUL or on consume/abort, so they
    // already sit stable for the whole of S_OUT and can drive the outputs.
    assign out_data  = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    // mul_a/mul_b double as the operand registers: loaded on accept, zeroed
    // after the single S_MUL cycle so they read 0 whenever mul_exe is low.
    // in_ready is a flop so it stays low through reset and rises one cycle
    // after reset is released.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state     <= S_IDLE;
            last_q    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            mul_exe   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else if (clr) begin
            state     <= S_IDLE;
            last_q    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mul_exe   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        mul_a    <= in_a;
                        mul_b    <= in_b;
                        last_q   <= in_last;
                        mul_exe  <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= S_MUL;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                S_MUL: begin
                    acc     <= acc_next;
                    ovf     <= ovf | add_ovf;
                    cnt     <= cnt + CNT_W'(1);
                    mul_exe <= 1'b0;
                    mul_a   <= '0;
                    mul_b   <= '0;
                    // cnt still holds the pre-increment value here.
                    if (last_q || (cnt == CNT_W'(COUNT - 1))) begin
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= S_OUT;
                    end else begin
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    mul_exe   <= 1'b0;
                end
            endcase
        end
    end

endmodule
